// File: rtl/gpu_cmd_tx_if.sv
// Command-source and GPU-bus signal bundle for gpu_cmd_tx.
// The slave modport is the transmitter's view; master is the CPU/GPU side.
interface gpu_cmd_tx_if #(
  parameter int FIFO_DEPTH = 4
);
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [1:0]                    cmd_code;
  logic [7:0]                    cmd_data;
  logic [1:0]                    interrupt_out;
  logic [7:0]                    data_out;
  logic                          interrupt_enable;
  logic                          busy;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic [15:0]                   sent_count;

  modport master (
    output cmd_valid, cmd_code, cmd_data,
    input  cmd_ready, interrupt_out, data_out, interrupt_enable,
    input  busy, fifo_count, sent_count
  );

  modport slave (
    input  cmd_valid, cmd_code, cmd_data,
    output cmd_ready, interrupt_out, data_out, interrupt_enable,
    output busy, fifo_count, sent_count
  );
endinterface

// File: rtl/gpu_cmd_tx.sv
// GPU command transmitter: FIFO-buffered commands serialised onto the GPU bus
// with programmable setup / strobe pulse / hold timing.
module gpu_cmd_tx #(
  parameter int          FIFO_DEPTH   = 4,
  parameter int          SETUP_CYCLES = 2,
  parameter int          PULSE_CYCLES = 2,
  parameter int          HOLD_CYCLES  = 1,
  parameter logic [15:0] SENT_INIT    = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  gpu_cmd_tx_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  state_t        r_state;
  logic [15:0]   r_cnt;
  logic          r_strobe;
  logic [1:0]    r_code;
  logic [7:0]    r_data;
  logic [15:0]   r_sent;

  logic          w_full;
  logic          w_push;
  logic          w_pop;

  // ready depends only on occupancy, so a full FIFO never accepts even on a pop cycle
  assign w_full = (r_count == CW'(FIFO_DEPTH));
  assign w_push = bus.cmd_valid && !w_full;
  assign w_pop  = (r_state == IDLE) && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.cmd_code, bus.cmd_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_strobe <= 1'b0;
      r_code   <= '0;
      r_data   <= '0;
      r_sent   <= SENT_INIT;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            {r_code, r_data} <= r_mem[r_rd_ptr];
            r_cnt            <= 16'(SETUP_CYCLES - 1);
            r_state          <= SETUP;
          end
        end
        SETUP: begin
          if (r_cnt == '0) begin
            r_strobe <= 1'b1;
            r_cnt    <= 16'(PULSE_CYCLES - 1);
            r_state  <= PULSE;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        PULSE: begin
          if (r_cnt == '0) begin
            r_strobe <= 1'b0;
            r_cnt    <= 16'(HOLD_CYCLES - 1);
            r_sent   <= r_sent + 16'd1;
            r_state  <= HOLD;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        HOLD: begin
          if (r_cnt == '0) r_state <= IDLE;
          else             r_cnt   <= r_cnt - 16'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready        = !w_full;
  assign bus.interrupt_out    = r_code;
  assign bus.data_out         = r_data;
  assign bus.interrupt_enable = r_strobe;
  assign bus.busy             = (r_state != IDLE) || (r_count != '0);
  assign bus.fifo_count       = r_count;
  assign bus.sent_count       = r_sent;
endmodule

// File: tb/tb_gpu_cmd_tx.sv
// Bench for gpu_cmd_tx: default, counter-preloaded and minimum-timing instances,
// driven by a cycle table plus directed and random sequences.
module tb_gpu_cmd_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gpu_cmd_tx_if #(.FIFO_DEPTH(4)) b0 ();
  gpu_cmd_tx_if #(.FIFO_DEPTH(4)) bw ();
  gpu_cmd_tx_if #(.FIFO_DEPTH(2)) bs ();

  gpu_cmd_tx u0 (.clk(clk), .reset(rst), .bus(b0));
  gpu_cmd_tx #(.SENT_INIT(16'hFFFE)) uw (.clk(clk), .reset(rst), .bus(bw));
  gpu_cmd_tx #(.FIFO_DEPTH(2), .SETUP_CYCLES(1), .PULSE_CYCLES(1), .HOLD_CYCLES(1))
    us (.clk(clk), .reset(rst), .bus(bs));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitors ----------------
  logic       sb_en = 1'b0, stab_en = 1'b0, per_en = 1'b0, rdy_en = 1'b0, sw_en = 1'b0;
  logic [9:0] exp_q[$];
  logic [9:0] sw_q[$];
  logic       prev_ie0 = 1'b0, prev_ies = 1'b0;
  logic [9:0] prev_bus0 = '0;
  logic       rise0, fall0, chg0, rises;
  int         stable0 = 1000, since_fall0 = 1000, last_rise0 = -1, max_cnt0 = 0;
  int         last_rises = -1, sw_rises = 0;

  always @(negedge clk) begin
    rise0 = b0.interrupt_enable && !prev_ie0;
    fall0 = !b0.interrupt_enable && prev_ie0;
    chg0  = ({b0.interrupt_out, b0.data_out} != prev_bus0);
    if (fall0) since_fall0 = 0; else if (since_fall0 < 1000) since_fall0++;
    if (chg0)  stable0 = 0;     else if (stable0 < 1000) stable0++;
    if (!rst && stab_en) begin
      if (chg0) check("bus_change_window", 32'(!b0.interrupt_enable && since_fall0 > 1), 32'd1);
      if (rise0) check("setup_window", 32'(stable0 >= 2), 32'd1);
    end
    if (!rst && sb_en && rise0) begin
      if (exp_q.size() == 0) check("order_unexpected_strobe", 32'd1, 32'd0);
      else check("order", 32'({b0.interrupt_out, b0.data_out}), 32'(exp_q.pop_front()));
      if (per_en && last_rise0 >= 0) check("period6", 32'(cyc - last_rise0), 32'd6);
      last_rise0 = cyc;
    end
    if (!rst && rdy_en) begin
      check("ready_vs_count", 32'(b0.cmd_ready), 32'(b0.fifo_count != 3'd4));
      if (int'(b0.fifo_count) > max_cnt0) max_cnt0 = int'(b0.fifo_count);
    end
    prev_ie0  = b0.interrupt_enable;
    prev_bus0 = {b0.interrupt_out, b0.data_out};

    rises = bs.interrupt_enable && !prev_ies;
    if (!rst && sw_en) begin
      check("sw_ready_vs_count", 32'(bs.cmd_ready), 32'(bs.fifo_count != 2'd2));
      if (rises) begin
        sw_rises++;
        if (sw_q.size() == 0) check("sw_order_unexpected_strobe", 32'd1, 32'd0);
        else check("sw_order", 32'({bs.interrupt_out, bs.data_out}), 32'(sw_q.pop_front()));
        if (last_rises >= 0) check("sw_period4", 32'(cyc - last_rises), 32'd4);
        last_rises = cyc;
      end
    end
    prev_ies = bs.interrupt_enable;
  end

  // ---------------- push helpers ----------------
  task automatic push0(input logic [1:0] c, input logic [7:0] d);
    int t = 0;
    b0.cmd_valid = 1'b1; b0.cmd_code = c; b0.cmd_data = d;
    while (!b0.cmd_ready && t < 100) begin step(); t++; end
    if (!b0.cmd_ready) check("push0_timeout", 32'd0, 32'd1);
    else begin step(); exp_q.push_back({c, d}); end
    b0.cmd_valid = 1'b0;
  endtask

  task automatic pushw(input logic [1:0] c, input logic [7:0] d);
    bw.cmd_valid = 1'b1; bw.cmd_code = c; bw.cmd_data = d;
    check("wrap_ready", 32'(bw.cmd_ready), 32'd1);
    step();
    bw.cmd_valid = 1'b0;
  endtask

  task automatic pushs(input logic [1:0] c, input logic [7:0] d);
    int t = 0;
    bs.cmd_valid = 1'b1; bs.cmd_code = c; bs.cmd_data = d;
    while (!bs.cmd_ready && t < 100) begin step(); t++; end
    if (!bs.cmd_ready) check("pushs_timeout", 32'd0, 32'd1);
    else begin step(); sw_q.push_back({c, d}); end
    bs.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle0(input string name);
    int t = 0;
    while (b0.busy && t < 200) begin step(); t++; end
    check(name, 32'(b0.busy), 32'd0);
  endtask

  // ---------------- table ----------------
  typedef struct {
    logic        v;
    logic [1:0]  c;
    logic [7:0]  d;
    logic [1:0]  e_out;
    logic [7:0]  e_data;
    logic        e_ie;
    logic        e_busy;
    logic [2:0]  e_cnt;
    logic [15:0] e_sent;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [31:0] act, exp;
    int seen;

    // row k: inputs applied before edge k, outputs expected just after edge k
    tbl[0]  = '{1'b1, 2'b00, 8'h41, 2'b00, 8'h00, 1'b0, 1'b1, 3'd1, 16'd0};
    tbl[1]  = '{1'b0, 2'b00, 8'h00, 2'b00, 8'h41, 1'b0, 1'b1, 3'd0, 16'd0};
    tbl[2]  = '{1'b0, 2'b00, 8'h00, 2'b00, 8'h41, 1'b0, 1'b1, 3'd0, 16'd0};
    tbl[3]  = '{1'b0, 2'b00, 8'h00, 2'b00, 8'h41, 1'b1, 1'b1, 3'd0, 16'd0};
    tbl[4]  = '{1'b0, 2'b00, 8'h00, 2'b00, 8'h41, 1'b1, 1'b1, 3'd0, 16'd0};
    tbl[5]  = '{1'b0, 2'b00, 8'h00, 2'b00, 8'h41, 1'b0, 1'b1, 3'd0, 16'd1};
    tbl[6]  = '{1'b0, 2'b00, 8'h00, 2'b00, 8'h41, 1'b0, 1'b0, 3'd0, 16'd1};
    tbl[7]  = '{1'b1, 2'b11, 8'hC3, 2'b00, 8'h41, 1'b0, 1'b1, 3'd1, 16'd1};
    tbl[8]  = '{1'b0, 2'b00, 8'h00, 2'b11, 8'hC3, 1'b0, 1'b1, 3'd0, 16'd1};
    tbl[9]  = '{1'b0, 2'b00, 8'h00, 2'b11, 8'hC3, 1'b0, 1'b1, 3'd0, 16'd1};
    tbl[10] = '{1'b0, 2'b00, 8'h00, 2'b11, 8'hC3, 1'b1, 1'b1, 3'd0, 16'd1};
    tbl[11] = '{1'b0, 2'b00, 8'h00, 2'b11, 8'hC3, 1'b1, 1'b1, 3'd0, 16'd1};
    tbl[12] = '{1'b0, 2'b00, 8'h00, 2'b11, 8'hC3, 1'b0, 1'b1, 3'd0, 16'd2};
    tbl[13] = '{1'b0, 2'b00, 8'h00, 2'b11, 8'hC3, 1'b0, 1'b0, 3'd0, 16'd2};

    b0.cmd_valid = 1'b0; b0.cmd_code = '0; b0.cmd_data = '0;
    bw.cmd_valid = 1'b0; bw.cmd_code = '0; bw.cmd_data = '0;
    bs.cmd_valid = 1'b0; bs.cmd_code = '0; bs.cmd_data = '0;
    rst = 1'b1;
    step(); step();

    check("rst_ready", 32'(b0.cmd_ready), 32'd1);
    check("rst_bus_strobe", 32'({b0.interrupt_out, b0.data_out, b0.interrupt_enable}), 32'd0);
    check("rst_busy_count", 32'({b0.busy, b0.fifo_count}), 32'd0);
    check("rst_sent", 32'(b0.sent_count), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      b0.cmd_valid = tbl[i].v; b0.cmd_code = tbl[i].c; b0.cmd_data = tbl[i].d;
      step();
      b0.cmd_valid = 1'b0;
      act = 32'({b0.interrupt_out, b0.data_out, b0.interrupt_enable, b0.busy, b0.fifo_count, b0.sent_count});
      exp = 32'({tbl[i].e_out, tbl[i].e_data, tbl[i].e_ie, tbl[i].e_busy, tbl[i].e_cnt, tbl[i].e_sent});
      check($sformatf("vec%0d{out,data,ie,busy,cnt,sent}", i), act, exp);
    end

    // burst into a full FIFO
    sb_en = 1'b1; per_en = 1'b1; rdy_en = 1'b1; last_rise0 = -1; max_cnt0 = 0;
    for (int i = 0; i < 6; i++) push0(2'(i % 4), 8'(i + 1));
    wait_idle0("burst_drain");
    rdy_en = 1'b0; per_en = 1'b0;
    check("burst_max_count", 32'(max_cnt0), 32'd4);
    check("burst_sent", 32'(b0.sent_count), 32'd8);
    check("burst_queue_empty", 32'(exp_q.size()), 32'd0);

    // random commands with random gaps under the setup/hold monitor
    stab_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      push0(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) step();
    end
    wait_idle0("rand_drain");
    stab_en = 1'b0;
    check("rand_sent", 32'(b0.sent_count), 32'd1008);
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    // reset while the strobe is high with three commands queued
    sb_en = 1'b0;
    for (int i = 0; i < 4; i++) push0(2'b10, 8'(8'hA0 + i));
    seen = 0;
    while (!b0.interrupt_enable && seen < 20) begin step(); seen++; end
    check("mid_strobe_high", 32'(b0.interrupt_enable), 32'd1);
    check("mid_count_pre", 32'(b0.fifo_count), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("mid_strobe_dropped", 32'(b0.interrupt_enable), 32'd0);
    check("mid_bus_cleared", 32'({b0.interrupt_out, b0.data_out}), 32'd0);
    check("mid_count_cleared", 32'(b0.fifo_count), 32'd0);
    check("mid_sent_cleared", 32'(b0.sent_count), 32'd0);
    step();
    rst = 1'b0;
    exp_q.delete();
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (b0.interrupt_enable || b0.busy) seen++;
    end
    check("post_reset_quiet", 32'(seen), 32'd0);

    // sent_count wrap on the preloaded instance
    check("wrap_init", 32'(bw.sent_count), 32'hFFFE);
    pushw(2'b01, 8'h80); repeat (5) step();
    check("wrap_sent1", 32'(bw.sent_count), 32'hFFFF);
    step();
    pushw(2'b01, 8'h05); repeat (5) step();
    check("wrap_sent2", 32'(bw.sent_count), 32'h0000);
    step();
    pushw(2'b11, 8'h00); repeat (5) step();
    check("wrap_sent3", 32'(bw.sent_count), 32'h0001);
    check("wrap_bus_last", 32'({bw.interrupt_out, bw.data_out}), 32'h300);

    // minimum timing, depth-2 instance
    sw_en = 1'b1;
    for (int i = 0; i < 10; i++) pushs(2'(i % 4), 8'(8'h10 + i));
    seen = 0;
    while (bs.busy && seen < 100) begin step(); seen++; end
    sw_en = 1'b0;
    check("sw_drain", 32'(bs.busy), 32'd0);
    check("sw_rises", 32'(sw_rises), 32'd10);
    check("sw_sent", 32'(bs.sent_count), 32'd10);
    check("sw_queue_empty", 32'(sw_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gpu_cmd_tx.md
Name: gpu_cmd_tx

Overview:
- CPU-side transmitter for the GPU command interface. It drives the 2-bit command code, the 8-bit data byte and the rising-edge command strobe into the GPU.
- Buffers commands from a valid/ready source in a small FIFO.
- Serialises them onto the GPU bus with programmable setup, pulse and hold timing, so every strobe rising edge sees stable code and data.
- Sits between the CPU I/O decode and the GPU's command inputs.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, 2..16.
- SETUP_CYCLES, 2, cycles code/data are stable before the strobe rises; >=1.
- PULSE_CYCLES, 2, cycles the strobe stays high; >=1.
- HOLD_CYCLES, 1, cycles code/data stay stable after the strobe falls; >=1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  source offers a command.
- cmd_ready  output  1  FIFO can accept; equals !full.
- cmd_code  input  2  00 store byte, 01 move cursor, 10 display/swap, 11 clear.
- cmd_data  input  8  payload byte.
- interrupt_out  output  2  command code to the GPU.
- data_out  output  8  data byte to the GPU.
- interrupt_enable  output  1  GPU strobe; the GPU acts on its rising edge.
- busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- sent_count  output  16  number of completed strobes; wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset (async, immediate):
  - FIFO empty; fifo_count = 0.
  - State IDLE.
  - interrupt_out = 0, data_out = 0, interrupt_enable = 0.
  - sent_count = 0, busy = 0, cmd_ready = 1.
  - A reset during PULSE drops the strobe immediately. The aborted command is discarded and not counted.
- Push: cmd_valid && cmd_ready at an edge writes {cmd_code, cmd_data} at the tail; fifo_count increments.
- Pop: performed only by the FSM, in IDLE.
- Simultaneous push and pop: allowed when not full; fifo_count is unchanged. When full, cmd_ready = 0 even if a pop occurs that cycle, so there is no same-cycle bypass of a full FIFO.
- FSM states: IDLE, SETUP, PULSE, HOLD. A single down-counter cnt serves all timed states.
  - IDLE: if the FIFO is non-empty, pop the head, register interrupt_out/data_out, cnt <= SETUP_CYCLES-1, go to SETUP. Otherwise stay.
  - SETUP: strobe low. If cnt == 0, set interrupt_enable <= 1, cnt <= PULSE_CYCLES-1, go to PULSE. Otherwise decrement cnt.
  - PULSE: strobe high. If cnt == 0, set interrupt_enable <= 0, cnt <= HOLD_CYCLES-1, increment sent_count, go to HOLD. Otherwise decrement cnt.
  - HOLD: strobe low, bus held. If cnt == 0, go to IDLE. Otherwise decrement cnt.
- Bus stability:
  - interrupt_out and data_out change only on the IDLE pop edge.
  - Between commands they hold the last transmitted value.
- interrupt_enable is a direct register output, so it is glitch-free.
- Timing:
  - A command pushed at edge T into an empty FIFO with the FSM in IDLE is popped at edge T+1.
  - The strobe rises at edge T+1+SETUP_CYCLES and falls PULSE_CYCLES edges later.
  - Back-to-back period is 1+SETUP+PULSE+HOLD cycles; 6 with defaults.
  - The strobe is low for at least HOLD+1+SETUP cycles between pulses.
- Ordering: strictly FIFO; no reordering, merging or dropping.
- No command interpretation: codes 00..11 are passed verbatim, including the cursor-move direction bit in data[7].
- Wrap: FIFO pointers wrap modulo FIFO_DEPTH; sent_count wraps modulo 2^16.

Test Plan:
- Single command: after reset, push code 00, data 0x41 at edge 0. Required response:
  - interrupt_out = 00 and data_out = 0x41 after edge 1.
  - interrupt_enable high after edges 3–4 and low from edge 5.
  - sent_count = 1; busy low after edge 6.
- Burst and full: hold cmd_valid with 6 commands, data 0x01..0x06, codes cycling 00, 01, 10, 11. Required response:
  - cmd_ready drops when fifo_count = 4.
  - All 6 are transmitted in order, one strobe per 6 cycles.
  - Final sent_count = 6.
- Setup/hold check: a bench monitor asserts interrupt_out/data_out never change while the strobe is high, or within SETUP cycles before a rise or HOLD cycles after a fall. Run 1000 random commands with random valid gaps; required response: zero violations.
- Reset mid-pulse: assert reset while interrupt_enable = 1 with 3 entries queued. Required response:
  - Strobe, bus and fifo_count are 0 in the same cycle.
  - sent_count = 0.
  - After release, no strobe occurs until a new push.
- Counter wrap: preload sent_count to 0xFFFE via a forced initial state, then send 3 commands. Required response: sent_count reads 0xFFFF, then 0x0000, then 0x0001.
- Parameter sweep: SETUP = 1, PULSE = 1, HOLD = 1, FIFO_DEPTH = 2. Required response:
  - Period is 4 cycles.
  - cmd_ready deasserts at fifo_count = 2.
  - Ordering is preserved for 10 commands.
